// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - per-neuron multiply-accumulate sequencer with requantization
// Walks one (layer, neuron) weight row, accumulates signed products, emits a saturated int8.
module neuron_mac #(
  parameter int ACC_W = 26,
  parameter int SHIFT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       layer,
  input  logic [3:0]       neuron,
  input  logic [10:0]      num_inputs,
  input  logic             relu_en,
  output logic [15:0]      weight_addr,
  input  logic [7:0]       weight_val,
  output logic [9:0]       act_addr,
  input  logic [7:0]       act_val,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result,
  output logic [ACC_W-1:0] acc_out
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(128));

  state_t                  state_q, state_d;
  logic [9:0]              idx_q, idx_d;
  logic [10:0]             n_q, n_d;
  logic [1:0]              layer_q, layer_d;
  logic [3:0]              neuron_q, neuron_d;
  logic                    relu_q, relu_d;
  logic                    valid_q, valid_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [7:0]              result_q, result_d;
  logic                    done_q, done_d;

  logic [10:0]             n_clamp;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] relu_v;

  always_comb begin
    n_clamp  = (num_inputs > 11'd1024) ? 11'd1024 : num_inputs;
    prod     = $signed(weight_val) * $signed(act_val);
    prod_ext = {{(ACC_W-16){prod[15]}}, prod};
    shifted  = acc_q >>> SHIFT;
    relu_v   = (relu_q && shifted[ACC_W-1]) ? '0 : shifted;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_d       = n_q;
    layer_d   = layer_q;
    neuron_d  = neuron_q;
    relu_d    = relu_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    result_d  = result_q;
    done_d    = 1'b0;
    // Data for an address issued in FETCH returns one cycle later and is summed on the following edge.
    valid_d   = (state_q == FETCH);
    if (valid_q) begin
      acc_d = acc_q + prod_ext;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          if (n_clamp != 11'd0) begin
            layer_d  = layer;
            neuron_d = neuron;
            relu_d   = relu_en;
            n_d      = n_clamp;
            idx_d    = 10'd0;
            state_d  = FETCH;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FETCH: begin
        if ({1'b0, idx_q} == n_q - 11'd1) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 10'd1;
        end
      end
      DRAIN: begin
        state_d = FINISH;
      end
      FINISH: begin
        acc_out_d = acc_q;
        if (relu_v > SAT_MAX) begin
          result_d = 8'sd127;
        end else if (relu_v < SAT_MIN) begin
          result_d = 8'h80;
        end else begin
          result_d = relu_v[7:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      layer_q   <= '0;
      neuron_q  <= '0;
      relu_q    <= 1'b0;
      valid_q   <= 1'b0;
      acc_q     <= '0;
      acc_out_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      layer_q   <= layer_d;
      neuron_q  <= neuron_d;
      relu_q    <= relu_d;
      valid_q   <= valid_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign weight_addr = {layer_q, neuron_q, idx_q};
  assign act_addr    = idx_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign acc_out     = acc_out_q;

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - scoreboard bench for neuron_mac
`timescale 1ns/1ps
module tb_neuron_mac;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, relu_en;
  logic [1:0]  layer;
  logic [3:0]  neuron;
  logic [10:0] num_inputs;
  logic [7:0]  weight_val, act_val;

  logic [15:0] weight_addr, s4_weight_addr;
  logic [9:0]  act_addr, s4_act_addr;
  logic        busy, done, s4_busy, s4_done;
  logic [7:0]  result, s4_result;
  logic [25:0] acc_out, s4_acc_out;

  neuron_mac #(.ACC_W(26), .SHIFT(0)) dut (
    .clk(clk), .reset(reset), .start(start), .layer(layer), .neuron(neuron),
    .num_inputs(num_inputs), .relu_en(relu_en), .weight_addr(weight_addr),
    .weight_val(weight_val), .act_addr(act_addr), .act_val(act_val),
    .busy(busy), .done(done), .result(result), .acc_out(acc_out)
  );

  neuron_mac #(.ACC_W(26), .SHIFT(4)) dut_s4 (
    .clk(clk), .reset(reset), .start(start), .layer(layer), .neuron(neuron),
    .num_inputs(num_inputs), .relu_en(relu_en), .weight_addr(s4_weight_addr),
    .weight_val(weight_val), .act_addr(s4_act_addr), .act_val(act_val),
    .busy(s4_busy), .done(s4_done), .result(s4_result), .acc_out(s4_acc_out)
  );

  logic [7:0] wmem [0:65535];
  logic [7:0] amem [0:1023];

  always @(posedge clk) begin
    weight_val <= wmem[weight_addr];
    act_val    <= amem[act_addr];
  end

  typedef struct {
    longint acc;
    longint r0;
    longint r4;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   done_cnt = 0;
  int   cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint requant(input longint acc, input int sh, input bit relu);
    longint s;
    s = acc >>> sh;
    if (relu && s < 0) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic run(input logic [1:0] l, input logic [3:0] nr, input logic [10:0] num,
                     input bit relu, input bit mid_start);
    int          n;
    longint      acc;
    exp_t        e;
    logic [15:0] a0;
    logic [15:0] ea;
    int          e0;
    int          d0;
    bit          seen;
    n   = (num > 11'd1024) ? 1024 : int'(num);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      ea  = {l, nr, 10'(i)};
      acc += longint'($signed(wmem[ea])) * longint'($signed(amem[i]));
    end
    e.acc = acc;
    e.r0  = requant(acc, 0, relu);
    e.r4  = requant(acc, 4, relu);
    sb.push_back(e);
    a0 = weight_addr;
    d0 = done_cnt;
    layer = l; neuron = nr; num_inputs = num; relu_en = relu; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
    for (int k = 0; k < n; k++) begin
      chk("weight_addr", weight_addr, {l, nr, 10'(k)});
      chk("act_addr", act_addr, k);
      chk("s4_weight_addr", s4_weight_addr, {l, nr, 10'(k)});
      if (mid_start && k == 0) begin
        start = 1'b1; layer = ~l; neuron = ~nr; num_inputs = 11'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (n > 0) chk("addr_hold", weight_addr, {l, nr, 10'(n - 1)});
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("done_seen", seen, 1);
    e = sb.pop_front();
    if (seen) begin
      chk("latency", cyc - e0, (n == 0) ? 1 : n + 2);
      chk("busy_at_done", busy, 0);
      chk("s4_done", s4_done, 1);
      chk("acc_out", $signed(acc_out), e.acc);
      chk("s4_acc_out", $signed(s4_acc_out), e.acc);
      chk("result", $signed(result), e.r0);
      chk("s4_result", $signed(s4_result), e.r4);
      if (n == 0) chk("n0_addr", weight_addr, a0);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("done_count", done_cnt - d0, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int dc;
    for (int i = 0; i < 65536; i++) wmem[i] = 8'h00;
    for (int i = 0; i < 1024; i++) amem[i] = 8'h00;
    reset = 1'b0; start = 1'b0; relu_en = 1'b0; layer = 2'd0; neuron = 4'd0; num_inputs = 11'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_waddr", weight_addr, 0);
    reset = 1'b1;
    @(negedge clk);

    wmem[16'h0000] = 8'(-3); wmem[16'h0001] = 8'd14; wmem[16'h0002] = 8'd3; wmem[16'h0003] = 8'(-8);
    amem[0] = 8'd10; amem[1] = 8'd2; amem[2] = 8'd5; amem[3] = 8'd1;
    run(2'd0, 4'd0, 11'd4, 1'b0, 1'b0);
    chk("t1_acc", $signed(acc_out), 5);
    chk("t1_result", $signed(result), 5);

    wmem[16'h4000] = 8'(-4); wmem[16'h4001] = 8'(-5);
    amem[0] = 8'd10; amem[1] = 8'd10;
    run(2'd1, 4'd0, 11'd2, 1'b0, 1'b0);
    chk("t2_result", $signed(result), -90);
    chk("t2_s4_result", $signed(s4_result), -6);
    run(2'd1, 4'd0, 11'd2, 1'b1, 1'b0);
    chk("t2_relu_result", $signed(result), 0);
    chk("t2_relu_acc", $signed(acc_out), -90);

    wmem[16'h0400] = 8'd4; wmem[16'h0401] = 8'(-6); wmem[16'h0402] = 8'd16; wmem[16'h0403] = 8'd8;
    amem[0] = 8'd127; amem[1] = 8'd0; amem[2] = 8'd127; amem[3] = 8'd127;
    run(2'd0, 4'd1, 11'd4, 1'b0, 1'b0);
    chk("t3_acc", $signed(acc_out), 3556);
    chk("t3_result", $signed(result), 127);

    wmem[16'h4400] = 8'd7; wmem[16'h4401] = 8'(-2);
    amem[0] = 8'd3; amem[1] = 8'd9;
    run(2'd1, 4'd1, 11'd2, 1'b0, 1'b1);

    // Abort an evaluation mid-FETCH with the asynchronous reset.
    wmem[16'h0000] = 8'(-3); wmem[16'h0001] = 8'd14; wmem[16'h0002] = 8'd3; wmem[16'h0003] = 8'(-8);
    amem[0] = 8'd10; amem[1] = 8'd2; amem[2] = 8'd5; amem[3] = 8'd1;
    dc = done_cnt;
    layer = 2'd0; neuron = 4'd0; num_inputs = 11'd4; relu_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_waddr", weight_addr, 0);
    chk("mid_rst_aaddr", act_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_acc", acc_out, 0);
    chk("mid_rst_s4_result", s4_result, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_rst_no_done", done_cnt - dc, 0);
    run(2'd0, 4'd0, 11'd4, 1'b0, 1'b0);
    chk("post_rst_result", $signed(result), 5);

    run(2'd0, 4'd0, 11'd0, 1'b0, 1'b0);
    chk("n0_result", $signed(result), 0);

    for (int i = 0; i < 1024; i++) begin
      wmem[{2'd2, 4'd3, 10'(i)}] = 8'($urandom_range(0, 255));
      amem[i] = 8'($urandom_range(0, 255));
    end
    wmem[{2'd3, 4'd3, 10'd0}] = 8'd99;
    run(2'd2, 4'd3, 11'd2000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
